orbit_frame_buffer: RTL and testbench
=====================================

Name: orbit_frame_buffer

Overview:
- Double-buffered (ping-pong) frame memory directly upstream of the orbit frame serializer.
- Collects 12-bit telemetry words from the acquisition side into the write bank.
- Presents the opposite bank to the serializer's read port (address in, word out).
- Swaps banks on every toggle of the serializer's bank-switch output, and reports fill, overflow, underrun and resync status.

Parameters:
- WIDTH, 12, data word width; the serializer ORs frame markers into bit WIDTH-1.
- AW, 11, address width; frame depth is 2**AW words (2048).
- MASK_MSB, 1, when 1, bit WIDTH-1 of every written word is forced to 0 so it cannot collide with markers.

Ports:
- iClkOrb  in  1  orbit clock (100 MHz/8), shared with the serializer.
- reset  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- iWrVal  in  1  write strobe, one word per asserted cycle.
- iWrFirst  in  1  qualifies iWrVal: this word is word 0 of a frame.
- iWrData  in  WIDTH  word to store.
- oWrReady  out  1  1 = write side accepts words (state FILL or IDLE).
- iSwitch  in  1  bank-switch level from the serializer; any toggle = swap.
- iRdAddr  in  AW  serializer read address.
- oRdData  out  WIDTH  word from the read bank at iRdAddr.
- oFill  out  AW+1  words written to the current write bank (0..2048).
- oFrameReady  out  1  write bank is full (state FULL).
- oOverflow  out  1  sticky: a word arrived while FULL.
- oUnderrun  out  1  sticky: a swap occurred before the write bank was full.
- oResync  out  1  sticky: iWrFirst arrived mid-frame.
- iClrFlags  in  1  clears the three sticky flags; a set event in the same cycle wins.

Behaviour:
- Storage: two banks of 2**AW x WIDTH. wr_bank selects the write bank; the read bank is ~wr_bank. Memory contents are not reset.
- Read path: oRdData = mem[~wr_bank][iRdAddr], combinational (distributed RAM). The serializer samples it one clock after driving the address, so data must settle within one cycle; a registered-output block RAM is not allowed.
- Swap detect: sw_q <= iSwitch. swap = iSwitch ^ sw_q. On swap: wr_bank <= ~wr_bank, write pointer <= 0, oFill <= 0.
- FSM states:
  - IDLE (reset state): waits for iWrFirst&iWrVal. The word goes to address 0, pointer becomes 1, go to FILL. Writes with iWrVal but no iWrFirst are dropped silently.
  - FILL: each iWrVal writes at the pointer; pointer and oFill increment. The write that makes oFill==2048 moves to FULL. Pointer is AW+1 bits wide, so there is no wrap.
  - FULL: oWrReady=0, oFrameReady=1. Any iWrVal is dropped and sets oOverflow.
- Swap handling:
  - Swap in FULL -> IDLE.
  - Swap in IDLE or FILL -> set oUnderrun, go to IDLE. The read side then serves the partial frame plus stale words, which is accepted.
- Swap and write in the same cycle: the swap applies first.
  - If iWrVal&iWrFirst, the word is written to the new bank at address 0, oFill=1, state FILL.
  - Otherwise the word is dropped, with no overflow.
- iWrFirst in FILL with pointer != 0: set oResync; the word is written at address 0, pointer=1, stay FILL.
- MSB masking: with MASK_MSB=1, stored word = {1'b0, iWrData[WIDTH-2:0]}.
- Reset values: wr_bank=0, sw_q=0 (matches serializer reset level), pointer=0, oFill=0, state IDLE, oWrReady=1, oFrameReady=0, all sticky flags 0. Reset mid-frame discards progress; the next frame needs iWrFirst.
- Latency: a written word is readable by the serializer only after the next swap.

Decomposition:
- Package orbit_pkg: WIDTH/AW defaults, FRAME_WORDS=2048, FSM state enum {IDLE, FILL, FULL}.
- One sub-module, orbit_dpram: single bank, synchronous write, asynchronous read, instantiated twice. Write enable gated by wr_bank.

Test Plan:
- Reset, then 2048 writes starting with iWrFirst, data = address. Expect oFill=2048, oFrameReady=1. Toggle iSwitch; read addr 5 -> oRdData=12'h005.
- Write iWrData=12'hFFF with MASK_MSB=1, then swap. Expect readback 12'h7FF.
- Fill 100 words, toggle iSwitch. Expect oUnderrun=1, oFill=0, state IDLE, wr_bank flipped.
- After FULL, 3 extra iWrVal. Expect oOverflow=1, oFill stays 2048, address 0 word unchanged after swap.
- At pointer 10, assert iWrFirst with data 12'h123. Expect oResync=1, oFill=1, addr 0 =12'h123 after completing the frame and swapping.
- Swap and iWrVal&iWrFirst in the same cycle. Expect word in the new bank at addr 0, oFill=1; then iClrFlags clears all sticky flags to 0.

Source files
------------

// File: rtl/orbit_pkg.sv
// Shared constants for the orbit frame buffer.
// Default geometry and write-side FSM state encodings.
package orbit_pkg;

    localparam int DEF_WIDTH   = 12;
    localparam int DEF_AW      = 11;
    localparam int FRAME_WORDS = 2048;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

endpackage

// File: rtl/orbit_dpram.sv
// One frame bank: synchronous write, asynchronous read.
// Maps to distributed RAM so read data settles within a cycle.
module orbit_dpram #(
    parameter int WIDTH = 12,
    parameter int AW    = 11
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [2**AW];

    // Store one word per enabled cycle
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/orbit_frame_buffer.sv
// Ping-pong frame memory feeding the orbit frame serializer.
// Fills one bank while the serializer reads the other; swaps on iSwitch toggles.
module orbit_frame_buffer
    import orbit_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AW       = DEF_AW,
    parameter bit MASK_MSB = 1'b1
) (
    input  logic             iClkOrb,
    input  logic             reset,
    input  logic             iWrVal,
    input  logic             iWrFirst,
    input  logic [WIDTH-1:0] iWrData,
    output logic             oWrReady,
    input  logic             iSwitch,
    input  logic [AW-1:0]    iRdAddr,
    output logic [WIDTH-1:0] oRdData,
    output logic [AW:0]      oFill,
    output logic             oFrameReady,
    output logic             oOverflow,
    output logic             oUnderrun,
    output logic             oResync,
    input  logic             iClrFlags
);

    localparam logic [AW:0] LAST = (AW+1)'((1 << AW) - 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic             sw_q;
    logic             bank_q, bank_d;
    logic [AW:0]      ptr_q, ptr_d;
    logic [1:0]       state_q, state_d;
    logic             ovf_q, und_q, rsy_q;
    logic             ovf_set, und_set, rsy_set;
    logic             swap;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd [2];

    assign swap = iSwitch ^ sw_q;

    // Keep the MSB clear so serializer frame markers cannot collide
    always_comb begin
        wdata = iWrData;
        if (MASK_MSB) begin
            wdata[WIDTH-1] = 1'b0;
        end
    end

    // Write-side control: swap takes priority, then the fill FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bank_d  = bank_q;
        ovf_set = 1'b0;
        und_set = 1'b0;
        rsy_set = 1'b0;
        we      = 1'b0;
        waddr   = ptr_q[AW-1:0];
        if (swap) begin
            bank_d  = ~bank_q;
            ptr_d   = '0;
            state_d = S_IDLE;
            und_set = (state_q != S_FULL);
            if (iWrVal && iWrFirst) begin
                we      = 1'b1;
                waddr   = '0;
                ptr_d   = ONE;
                state_d = S_FILL;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iWrVal && iWrFirst) begin
                        we      = 1'b1;
                        waddr   = '0;
                        ptr_d   = ONE;
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    if (iWrVal) begin
                        we = 1'b1;
                        if (iWrFirst && ptr_q != '0) begin
                            rsy_set = 1'b1;
                            waddr   = '0;
                            ptr_d   = ONE;
                        end else begin
                            ptr_d = ptr_q + ONE;
                            if (ptr_q == LAST) begin
                                state_d = S_FULL;
                            end
                        end
                    end
                end
                S_FULL: begin
                    ovf_set = iWrVal;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Register control state and sticky flags; a set beats a clear
    always_ff @(posedge iClkOrb) begin
        if (reset) begin
            sw_q    <= 1'b0;
            bank_q  <= 1'b0;
            ptr_q   <= '0;
            state_q <= S_IDLE;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
            rsy_q   <= 1'b0;
        end else begin
            sw_q    <= iSwitch;
            bank_q  <= bank_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
            ovf_q   <= ovf_set | (ovf_q & ~iClrFlags);
            und_q   <= und_set | (und_q & ~iClrFlags);
            rsy_q   <= rsy_set | (rsy_q & ~iClrFlags);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        orbit_dpram #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_bank (
            .clk_i   (iClkOrb),
            .we_i    (we && !reset && (bank_d == 1'(b))),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .raddr_i (iRdAddr),
            .rdata_o (rd[b])
        );
    end

    assign oRdData     = rd[~bank_q];
    assign oFill       = ptr_q;
    assign oWrReady    = (state_q != S_FULL);
    assign oFrameReady = (state_q == S_FULL);
    assign oOverflow   = ovf_q;
    assign oUnderrun   = und_q;
    assign oResync     = rsy_q;

endmodule

// File: tb/tb_orbit_frame_buffer.sv
// Scoreboard bench for orbit_frame_buffer.
// Frame-level reference model predicts status and readback every cycle.
module tb_orbit_frame_buffer;

    logic        iClkOrb = 1'b0;
    logic        reset;
    logic        iWrVal, iWrFirst;
    logic [11:0] iWrData;
    logic        oWrReady;
    logic        iSwitch;
    logic [10:0] iRdAddr;
    logic [11:0] oRdData;
    logic [11:0] oFill;
    logic        oFrameReady, oOverflow, oUnderrun, oResync;
    logic        iClrFlags;

    orbit_frame_buffer dut (
        .iClkOrb     (iClkOrb),
        .reset       (reset),
        .iWrVal      (iWrVal),
        .iWrFirst    (iWrFirst),
        .iWrData     (iWrData),
        .oWrReady    (oWrReady),
        .iSwitch     (iSwitch),
        .iRdAddr     (iRdAddr),
        .oRdData     (oRdData),
        .oFill       (oFill),
        .oFrameReady (oFrameReady),
        .oOverflow   (oOverflow),
        .oUnderrun   (oUnderrun),
        .oResync     (oResync),
        .iClrFlags   (iClrFlags)
    );

    always #5 iClkOrb = ~iClkOrb;

    typedef struct {
        int          fill;
        bit          rdy, frd, ovf, und, rsy, rv;
        logic [11:0] rd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: frame bookkeeping in plain terms
    bit [11:0] mm [2][2048];
    bit        mv [2][2048];
    int        m_fill;
    bit        m_framing, m_wb, m_prev_sw;
    bit        m_ovf, m_und, m_rsy;

    function automatic void m_reset();
        m_fill = 0; m_framing = 0; m_wb = 0; m_prev_sw = 0;
        m_ovf = 0; m_und = 0; m_rsy = 0;
    endfunction

    function automatic void m_write(int a, logic [11:0] d);
        mm[m_wb][a] = d & 12'h7FF;
        mv[m_wb][a] = 1'b1;
    endfunction

    function automatic void m_step(bit v, bit f, logic [11:0] d,
                                   bit sw, bit clr);
        bit full, o, u, r;
        full = m_framing && m_fill == 2048;
        o = 0; u = 0; r = 0;
        if (sw != m_prev_sw) begin
            u = !full;
            m_wb = !m_wb;
            m_fill = 0;
            m_framing = 0;
            if (v && f) begin
                m_write(0, d);
                m_fill = 1;
                m_framing = 1;
            end
        end else if (!m_framing) begin
            if (v && f) begin
                m_write(0, d);
                m_fill = 1;
                m_framing = 1;
            end
        end else if (full) begin
            o = v;
        end else if (v) begin
            if (f) begin
                r = 1;
                m_write(0, d);
                m_fill = 1;
            end else begin
                m_write(m_fill, d);
                m_fill++;
            end
        end
        m_prev_sw = sw;
        m_ovf = o | (m_ovf & !clr);
        m_und = u | (m_und & !clr);
        m_rsy = r | (m_rsy & !clr);
    endfunction

    function automatic exp_t m_expect(logic [10:0] ra);
        exp_t e;
        bit full;
        full  = m_framing && m_fill == 2048;
        e.fill = m_fill;
        e.rdy  = !full;
        e.frd  = full;
        e.ovf  = m_ovf;
        e.und  = m_und;
        e.rsy  = m_rsy;
        e.rv   = mv[!m_wb][ra];
        e.rd   = mm[!m_wb][ra];
        return e;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after posedge
    task automatic cyc(input bit v, input bit f, input logic [11:0] d,
                       input bit tog, input bit clr, input bit rst,
                       input logic [10:0] ra);
        iWrVal = v; iWrFirst = f; iWrData = d;
        if (tog) iSwitch = ~iSwitch;
        iClrFlags = clr; reset = rst; iRdAddr = ra;
        q.push_back(m_expect(ra));
        if (rst) m_reset();
        else m_step(v, f, d, iSwitch, clr);
        @(posedge iClkOrb); #1;
    endtask

    task automatic idle(input int n, input logic [10:0] ra);
        for (int i = 0; i < n; i++) cyc(0, 0, 12'h0, 0, 0, 0, ra);
    endtask

    function automatic void chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Monitor: compare each cycle's presented outputs to the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge iClkOrb);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fill", int'(oFill), e.fill);
                chk("wr_ready", int'(oWrReady), int'(e.rdy));
                chk("frame_ready", int'(oFrameReady), int'(e.frd));
                chk("overflow", int'(oOverflow), int'(e.ovf));
                chk("underrun", int'(oUnderrun), int'(e.und));
                chk("resync", int'(oResync), int'(e.rsy));
                if (e.rv) chk("rd_data", int'(oRdData), int'(e.rd));
            end
        end
    end

    initial begin
        int wait_n;
        iWrVal = 0; iWrFirst = 0; iWrData = '0; iSwitch = 0;
        iRdAddr = '0; iClrFlags = 0; reset = 1;
        m_reset();
        @(posedge iClkOrb); #1;
        cyc(0, 0, 12'h0, 0, 0, 1, 11'd0);
        idle(2, 11'd0);

        // Full frame with data = address, overflow writes, swap, readback
        for (int a = 0; a < 2048; a++)
            cyc(1, a == 0, 12'(a), 0, 0, 0, 11'($urandom_range(2047)));
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 12'hABC, 0, 0, 0, 11'd0);
        cyc(0, 0, 12'h0, 1, 0, 0, 11'd0);
        idle(1, 11'd5);
        idle(1, 11'd0);
        idle(1, 11'd2047);

        // MSB masking, then partial-frame swap
        cyc(1, 1, 12'hFFF, 0, 0, 0, 11'd0);
        cyc(0, 0, 12'h0, 1, 0, 0, 11'd0);
        idle(2, 11'd0);
        cyc(0, 0, 12'h0, 0, 1, 0, 11'd0);

        // 100-word underrun
        for (int a = 0; a < 100; a++)
            cyc(1, a == 0, 12'($urandom), 0, 0, 0, 11'($urandom_range(2047)));
        cyc(0, 0, 12'h0, 1, 0, 0, 11'd0);
        idle(2, 11'd50);
        cyc(0, 0, 12'h0, 0, 1, 0, 11'd0);

        // Resync at pointer 10, then complete and swap
        for (int a = 0; a < 10; a++)
            cyc(1, a == 0, 12'($urandom), 0, 0, 0, 11'd0);
        cyc(1, 1, 12'h123, 0, 0, 0, 11'd0);
        for (int a = 1; a < 2048; a++)
            cyc(1, 0, 12'($urandom), 0, 0, 0, 11'($urandom_range(2047)));
        cyc(0, 0, 12'h0, 1, 0, 0, 11'd0);
        idle(2, 11'd0);

        // Swap together with a first word, then clear with concurrent set
        cyc(1, 1, 12'h456, 1, 0, 0, 11'd0);
        cyc(1, 0, 12'h001, 0, 0, 0, 11'd0);
        cyc(0, 0, 12'h0, 1, 0, 0, 11'd0);
        cyc(0, 0, 12'h0, 1, 1, 0, 11'd0);
        cyc(0, 0, 12'h0, 0, 1, 0, 11'd0);
        idle(2, 11'd0);

        // Randomized traffic including rare swaps, clears and resets
        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(99) < 80, $urandom_range(99) < 2,
                12'($urandom), $urandom_range(999) < 3,
                $urandom_range(99) < 3, $urandom_range(1999) < 2,
                11'($urandom_range(2047)));
        idle(2, 11'd0);

        wait_n = 0;
        while (q.size() > 0 && wait_n < 10) begin
            @(posedge iClkOrb);
            wait_n++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
